gsim_param: RTL and testbench



---
 rtl/gsim_pkg.sv | 35 +++
 rtl/gsim_row_pe.sv | 55 +++++
 rtl/gsim_param.sv | 220 ++++++++++++++++++++++
 tb/tb_gsim_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared types, constants and width helpers
// for the parametrised Gauss-Seidel solver.
package gsim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  localparam int COEF1       = 13;
  localparam int COEF2       = -6;
  localparam int COEF3       = 1;
  localparam int RECIP       = 52429;
  localparam int RECIP_SHIFT = 20;
  localparam int RECIP_W     = 17;

  function automatic int s_width(input int xw);
    return xw + 6;
  endfunction

  function automatic int p_width(input int xw);
    return xw + 6 + RECIP_W;
  endfunction

  function automatic longint sat_max(input int xw);
    return (64'sd1 <<< (xw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int xw);
    return -(64'sd1 <<< (xw - 1));
  endfunction

endpackage

// File: rtl/gsim_row_pe.sv
// Combinational row evaluator: weighted neighbour
// sum, divide-by-20 via reciprocal, saturate, |delta|.
module gsim_row_pe
  import gsim_pkg::*;
#(
  parameter int X_WIDTH = 32,
  parameter int SW      = s_width(X_WIDTH)
) (
  input  logic signed [X_WIDTH-1:0] x_m1,
  input  logic signed [X_WIDTH-1:0] x_p1,
  input  logic signed [X_WIDTH-1:0] x_m2,
  input  logic signed [X_WIDTH-1:0] x_p2,
  input  logic signed [X_WIDTH-1:0] x_m3,
  input  logic signed [X_WIDTH-1:0] x_p3,
  input  logic signed [X_WIDTH-1:0] x_old,
  input  logic signed [SW-1:0]      b_al,
  output logic signed [X_WIDTH-1:0] x_new,
  output logic        [X_WIDTH:0]   delta
);

  localparam int PW = p_width(X_WIDTH);
  localparam int DW = X_WIDTH + 1;

  localparam logic signed [SW-1:0] C1 = SW'(COEF1);
  localparam logic signed [SW-1:0] C2 = SW'(COEF2);
  localparam logic signed [SW-1:0] C3 = SW'(COEF3);
  localparam logic signed [PW-1:0] RC = PW'(RECIP);
  localparam logic signed [PW-1:0] HI = PW'(sat_max(X_WIDTH));
  localparam logic signed [PW-1:0] LO = PW'(sat_min(X_WIDTH));

  logic signed [SW-1:0] s;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] q;
  logic signed [DW-1:0] d;

  // S, floor(S*RECIP >> SHIFT), clamp, and magnitude of the change
  always_comb begin
    s = b_al
      + C1 * (SW'(x_m1) + SW'(x_p1))
      + C2 * (SW'(x_m2) + SW'(x_p2))
      + C3 * (SW'(x_m3) + SW'(x_p3));
    p = PW'(s) * RC;
    q = p >>> RECIP_SHIFT;
    if (q > HI) begin
      x_new = HI[X_WIDTH-1:0];
    end else if (q < LO) begin
      x_new = LO[X_WIDTH-1:0];
    end else begin
      x_new = q[X_WIDTH-1:0];
    end
    d = DW'(x_new) - DW'(x_old);
    delta = d[DW-1] ? $unsigned(-d) : $unsigned(d);
  end

endmodule

// File: rtl/gsim_param.sv
// Gauss-Seidel banded solver: load b, sweep rows,
// stream x out over a valid/ready channel.
module gsim_param
  import gsim_pkg::*;
#(
  parameter int N          = 16,
  parameter int B_WIDTH    = 16,
  parameter int X_WIDTH    = 32,
  parameter int FRAC       = 16,
  parameter int ITER_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_en,
  input  logic signed [B_WIDTH-1:0] b_in,
  input  logic [ITER_WIDTH-1:0]     max_iter,
  input  logic                      conv_en,
  input  logic [X_WIDTH-1:0]        tol,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [X_WIDTH-1:0] x_out,
  output logic [$clog2(N)-1:0]      out_idx,
  output logic                      out_last,
  output logic [ITER_WIDTH-1:0]     iter_cnt,
  output logic                      converged,
  output logic                      busy
);

  localparam int IW = $clog2(N);
  localparam int SW = s_width(X_WIDTH);
  localparam int DW = X_WIDTH + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state_q, state_d;
  logic signed [B_WIDTH-1:0] b_q [N];
  logic signed [B_WIDTH-1:0] b_d [N];
  logic signed [X_WIDTH-1:0] x_q [N];
  logic signed [X_WIDTH-1:0] x_d [N];
  logic [IW-1:0] cnt_q, cnt_d, row_q, row_d, idx_q, idx_d;
  logic [ITER_WIDTH-1:0] lim_q, lim_d, iter_q, iter_d;
  logic [X_WIDTH-1:0] tol_q, tol_d;
  logic [DW-1:0] dmax_q, dmax_d, dmax_nx;
  logic cen_q, cen_d, conv_q, conv_d;
  logic val_q, val_d, last_q, last_d, busy_q, busy_d;
  logic signed [X_WIDTH-1:0] xo_q, xo_d;

  logic signed [X_WIDTH-1:0] xm [1:3];
  logic signed [X_WIDTH-1:0] xp [1:3];
  logic signed [X_WIDTH-1:0] x_new;
  logic signed [SW-1:0] b_al;
  logic [DW-1:0] delta;
  logic go;

  // Gather the current row's neighbours, zero beyond the edges
  always_comb begin
    for (int k = 1; k <= 3; k++) begin
      xm[k] = '0;
      xp[k] = '0;
      if (int'(row_q) >= k) begin
        xm[k] = x_q[IW'(int'(row_q) - k)];
      end
      if (int'(row_q) + k < N) begin
        xp[k] = x_q[IW'(int'(row_q) + k)];
      end
    end
    b_al = SW'(b_q[row_q]) <<< FRAC;
  end

  gsim_row_pe #(
    .X_WIDTH(X_WIDTH),
    .SW     (SW)
  ) u_pe (
    .x_m1 (xm[1]),
    .x_p1 (xp[1]),
    .x_m2 (xm[2]),
    .x_p2 (xp[2]),
    .x_m3 (xm[3]),
    .x_p3 (xp[3]),
    .x_old(x_q[row_q]),
    .b_al (b_al),
    .x_new(x_new),
    .delta(delta)
  );

  // Next-state for the FSM, register files and output stream
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    iter_d  = iter_q;
    tol_d   = tol_q;
    dmax_d  = dmax_q;
    cen_d   = cen_q;
    conv_d  = conv_q;
    val_d   = val_q;
    last_d  = last_q;
    xo_d    = xo_q;
    go      = 1'b0;
    dmax_nx = (row_q == '0 || delta > dmax_q) ? delta : dmax_q;
    unique case (state_q)
      IDLE: begin
        if (in_en) begin
          b_d[0] = b_in;
          for (int i = 0; i < N; i++) begin
            x_d[i] = '0;
          end
          lim_d   = (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
          cen_d   = conv_en;
          tol_d   = tol;
          iter_d  = '0;
          conv_d  = 1'b0;
          cnt_d   = IW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_en) begin
          b_d[cnt_q] = b_in;
          cnt_d = cnt_q + IW'(1);
          if (cnt_q == LAST) begin
            row_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        x_d[row_q] = x_new;
        dmax_d = dmax_nx;
        if (row_q == LAST) begin
          row_d  = '0;
          iter_d = iter_q + ITER_WIDTH'(1);
          if (cen_q && dmax_nx <= {1'b0, tol_q}) begin
            conv_d = 1'b1;
            go = 1'b1;
          end else if (iter_q + ITER_WIDTH'(1) == lim_q) begin
            go = 1'b1;
          end
        end else begin
          row_d = row_q + IW'(1);
        end
        if (go) begin
          state_d = OUT;
          val_d   = 1'b1;
          idx_d   = '0;
          xo_d    = x_q[0];
          last_d  = 1'b0;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_q) begin
            val_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + IW'(1);
            xo_d   = x_q[idx_q + IW'(1)];
            last_d = (idx_q + IW'(1) == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, cleared by async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
      cnt_q  <= '0;
      row_q  <= '0;
      idx_q  <= '0;
      lim_q  <= '0;
      iter_q <= '0;
      tol_q  <= '0;
      dmax_q <= '0;
      cen_q  <= 1'b0;
      conv_q <= 1'b0;
      val_q  <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      xo_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      iter_q  <= iter_d;
      tol_q   <= tol_d;
      dmax_q  <= dmax_d;
      cen_q   <= cen_d;
      conv_q  <= conv_d;
      val_q   <= val_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      xo_q    <= xo_d;
    end
  end

  assign out_valid = val_q;
  assign x_out     = xo_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign iter_cnt  = iter_q;
  assign converged = conv_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gsim_param.sv
// Bench for gsim_param: directed and random problems
// against a plain-arithmetic Gauss-Seidel model.
module tb_gsim_param;

  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_en, sel4, conv_en, out_ready;
  logic signed [15:0] b_in;
  logic [7:0] max_iter;
  logic [31:0] tol;
  logic en16, en4;
  assign en16 = in_en & ~sel4;
  assign en4  = in_en & sel4;

  logic ov16, ol16, cv16, bz16;
  logic signed [31:0] xo16;
  logic [3:0] oi16;
  logic [7:0] ic16;
  logic ov4, ol4, cv4, bz4;
  logic signed [31:0] xo4;
  logic [1:0] oi4;
  logic [7:0] ic4;

  gsim_param #(.N(16)) u_dut (
    .clk(clk), .reset(reset), .in_en(en16), .b_in(b_in),
    .max_iter(max_iter), .conv_en(conv_en), .tol(tol),
    .out_valid(ov16), .out_ready(out_ready), .x_out(xo16),
    .out_idx(oi16), .out_last(ol16), .iter_cnt(ic16),
    .converged(cv16), .busy(bz16)
  );

  gsim_param #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_en(en4), .b_in(b_in),
    .max_iter(max_iter), .conv_en(conv_en), .tol(tol),
    .out_valid(ov4), .out_ready(out_ready), .x_out(xo4),
    .out_idx(oi4), .out_last(ol4), .iter_cnt(ic4),
    .converged(cv4), .busy(bz4)
  );

  logic ov, ol, cv, bz;
  logic signed [31:0] xo;
  int oi;
  logic [7:0] ic;

  always_comb begin
    if (sel4) begin
      ov = ov4; ol = ol4; cv = cv4; bz = bz4;
      xo = xo4; oi = int'(oi4); ic = ic4;
    end else begin
      ov = ov16; ol = ol16; cv = cv16; bz = bz16;
      xo = xo16; oi = int'(oi16); ic = ic16;
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  longint mb [64];
  longint mx [64];
  int m_it;
  bit m_cv;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint xg(input int j, input int n);
    if (j < 0 || j >= n) return 0;
    return mx[j];
  endfunction

  // Reference: in-place sweeps with the textbook update rule
  task automatic model(input int n, input int mi, input bit ce,
                       input longint tl);
    int lim;
    bit done;
    longint s, nx, d, dm;
    lim = (mi == 0) ? 1 : mi;
    for (int i = 0; i < 64; i++) mx[i] = 0;
    m_it = 0;
    m_cv = 1'b0;
    done = 1'b0;
    while (!done) begin
      dm = 0;
      for (int i = 0; i < n; i++) begin
        s = mb[i] * 65536
          + 13 * (xg(i - 1, n) + xg(i + 1, n))
          - 6 * (xg(i - 2, n) + xg(i + 2, n))
          + (xg(i - 3, n) + xg(i + 3, n));
        nx = (s * 52429) >>> 20;
        if (nx > XMAX) nx = XMAX;
        if (nx < XMIN) nx = XMIN;
        d = nx - mx[i];
        if (d < 0) d = -d;
        if (d > dm) dm = d;
        mx[i] = nx;
      end
      m_it++;
      if (ce && dm <= tl) begin
        m_cv = 1'b1;
        done = 1'b1;
      end else if (m_it == lim) begin
        done = 1'b1;
      end
    end
  endtask

  task automatic load(input int n, input int mi, input bit ce,
                      input logic [31:0] tl, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_en = 1'b1;
      b_in = 16'(mb[i]);
      if (i == 0) begin
        max_iter = 8'(mi);
        conv_en = ce;
        tol = tl;
      end else begin
        max_iter = 8'($urandom);
        conv_en = 1'($urandom);
        tol = $urandom;
      end
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_en = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic stream(input int n, input int rmode);
    int k;
    int e;
    int cyc;
    bit rdy;
    k = 0;
    while (ov !== 1'b1 && k < 100 * n + 400) begin
      @(negedge clk);
      k++;
    end
    chk("valid_rise", 64'(ov), 64'd1);
    if (ov !== 1'b1) return;
    chk("iter_cnt_out", 64'(ic), 64'(m_it));
    chk("converged_out", 64'(cv), 64'(m_cv));
    e = 0;
    cyc = 0;
    while (e < n && cyc < 4 * n + 20) begin
      chk("valid", 64'(ov), 64'd1);
      chk("idx", 64'(oi), 64'(e));
      chk("x_out", 64'(xo), mx[e]);
      chk("last", 64'(ol), 64'(e == n - 1));
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) e++;
    end
    out_ready = 1'b0;
    chk("beats", 64'(e), 64'(n));
    chk("valid_drop", 64'(ov), 64'd0);
    chk("busy_drop", 64'(bz), 64'd0);
    chk("iter_cnt_end", 64'(ic), 64'(m_it));
    chk("converged_end", 64'(cv), 64'(m_cv));
  endtask

  task automatic rand_b(input int n);
    for (int i = 0; i < n; i++) mb[i] = longint'($signed(16'($urandom)));
  endtask

  initial begin
    int k;
    int mi;
    bit ce;
    logic [31:0] tl;
    longint orig [16];
    orig = '{100, -250, 37, 4000, -1200, 5, 77, -9,
             3000, 0, -32768, 32767, 12, -600, 450, 1};
    reset = 1'b1;
    in_en = 1'b0;
    sel4 = 1'b0;
    b_in = '0;
    max_iter = '0;
    conv_en = 1'b0;
    tol = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_x_out", 64'(xo), 64'd0);
    chk("rst_idx", 64'(oi), 64'd0);
    chk("rst_last", 64'(ol), 64'd0);
    chk("rst_iter", 64'(ic), 64'd0);
    chk("rst_conv", 64'(cv), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    reset = 1'b0;

    // N=4 single sweep with hand-computed values
    sel4 = 1'b1;
    mb[0] = 20; mb[1] = 0; mb[2] = 0; mb[3] = 0;
    model(4, 1, 1'b0, 0);
    mx[0] = 65536; mx[1] = 42598; mx[2] = 8027; mx[3] = -4286;
    m_it = 1;
    m_cv = 1'b0;
    load(4, 1, 1'b0, 32'd0, 0);
    stream(4, 0);
    sel4 = 1'b0;

    // zero system converges after one sweep
    for (int i = 0; i < 16; i++) mb[i] = 0;
    model(16, 80, 1'b1, 0);
    load(16, 80, 1'b1, 32'd0, 0);
    stream(16, 0);

    // fixed vector, full 80 sweeps
    for (int i = 0; i < 16; i++) mb[i] = orig[i];
    model(16, 80, 1'b0, 0);
    load(16, 80, 1'b0, 32'd0, 0);
    stream(16, 0);

    // back-pressure pattern 1,0,0,1
    rand_b(16);
    model(16, 3, 1'b0, 0);
    load(16, 3, 1'b0, 32'd0, 0);
    stream(16, 1);

    // gapless then gapped load with an in_en pulse in CALC
    rand_b(16);
    model(16, 4, 1'b0, 0);
    load(16, 4, 1'b0, 32'd0, 0);
    stream(16, 0);
    load(16, 4, 1'b0, 32'd0, 3);
    @(negedge clk);
    @(negedge clk);
    chk("busy_calc", 64'(bz), 64'd1);
    in_en = 1'b1;
    b_in = 16'($urandom);
    @(negedge clk);
    in_en = 1'b0;
    stream(16, 2);

    // random problems, random ready
    repeat (5) begin
      rand_b(16);
      mi = int'($urandom_range(1, 6));
      ce = 1'($urandom);
      tl = $urandom_range(0, 32'h0010_0000);
      model(16, mi, ce, {32'd0, tl});
      load(16, mi, ce, tl, int'($urandom_range(0, 2)));
      stream(16, 2);
    end

    // reset during sweep 5, then max_iter=0 runs one sweep
    rand_b(16);
    load(16, 20, 1'b0, 32'd0, 0);
    k = 0;
    while (ic !== 8'd4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_sweep5", 64'(ic), 64'd4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bz), 64'd0);
    chk("abort_valid", 64'(ov), 64'd0);
    chk("abort_iter", 64'(ic), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rand_b(16);
    model(16, 0, 1'b0, 0);
    load(16, 0, 1'b0, 32'd0, 0);
    stream(16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
